// File: rtl/ps2_tx_if.sv
// ----------------------------------------------------------------------------
// ps2_tx_if
//   Single-word strobe/ack bus bundle between the wb_conbus_top slave port and
//   the PS/2 transmitter.
//   dat_i  [31:0]  write data      (master -> slave)
//   adr_i  [31:0]  address         (master -> slave)
//   we_i           write enable    (master -> slave)
//   stb_i          strobe          (master -> slave)
//   dat_o  [31:0]  read data       (slave  -> master)
//   ack_o          acknowledge     (slave  -> master)
// ----------------------------------------------------------------------------
interface ps2_tx_if;
    logic [31:0] dat_i;
    logic [31:0] adr_i;
    logic        we_i;
    logic        stb_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport master (
        output dat_i, adr_i, we_i, stb_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  dat_i, adr_i, we_i, stb_i,
        output dat_o, ack_o
    );
endinterface

// File: rtl/ps2_tx.sv
// ----------------------------------------------------------------------------
// ps2_tx
//   PS/2 host-to-device transmitter. A byte written to TXDATA is sent as an
//   11-bit frame (start 0, data LSB first, odd parity, stop 1) after holding
//   the PS/2 clock low for INHIBIT_CYC cycles and issuing request-to-send.
//   Both PS/2 lines are driven open-drain through registered enables.
//
//   clk          system clock
//   rst_n        synchronous reset, active-low
//   bus          strobe/ack slave port (dat_i, adr_i, we_i, stb_i, dat_o, ack_o)
//                  adr_i[2]=0 TXDATA : W latch byte / R {24'h0, byte}
//                  adr_i[2]=1 STATUS : R {27'h0, OVR, TMO, NAK, DONE, busy}
//                                      W 1-to-clear bits [4:1]
//   ps2_clk_i    PS/2 clock pin level (asynchronous)
//   ps2_data_i   PS/2 data pin level (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low
//   ps2_data_oe  1 = pull PS/2 data low
//   busy         transmission in progress
// ----------------------------------------------------------------------------
module ps2_tx #(
    parameter int unsigned INHIBIT_CYC = 12000,
    parameter int unsigned TIMEOUT_CYC = 2000000,
    parameter int unsigned FILTER_LEN  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    ps2_tx_if.slave        bus,
    input  logic           ps2_clk_i,
    input  logic           ps2_data_i,
    output logic           ps2_clk_oe,
    output logic           ps2_data_oe,
    output logic           busy
);

    localparam int unsigned MAX_CYC = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAITREL
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cyc_q, cyc_d;
    logic [3:0]            n_q, n_d;
    logic [7:0]            tx_q, tx_d;
    logic                  ovr_q, ovr_d, tmo_q, tmo_d, nak_q, nak_d, done_q, done_d;
    logic                  ack_q, ack_d;
    logic [31:0]           dat_o_q, dat_o_d;
    logic                  clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;

    logic [1:0]            clk_sync_q, dat_sync_q;
    logic [FILTER_LEN-1:0] clk_hist_q, clk_hist_d, dat_hist_q, dat_hist_d;
    logic                  pclk_q, pclk_d, pclk_prev_q, pdata_q, pdata_d;
    logic                  fall;

    logic                  acc, wr_tx, wr_st;
    logic                  set_ovr, set_tmo, set_nak, set_done;
    logic [10:0]           frame;
    logic [31:0]           rdata;
    logic                  unused_bits;

    assign unused_bits = ^{bus.adr_i[31:3], bus.adr_i[1:0], bus.dat_i[31:8]};

    // ---------------- input conditioning ----------------
    // The filtered level only moves once the whole history window agrees.
    always_comb begin
        clk_hist_d = {clk_hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
        dat_hist_d = {dat_hist_q[FILTER_LEN-2:0], dat_sync_q[1]};
        pclk_d  = pclk_q;
        pdata_d = pdata_q;
        if (&clk_hist_d)       pclk_d = 1'b1;
        else if (~|clk_hist_d) pclk_d = 1'b0;
        if (&dat_hist_d)       pdata_d = 1'b1;
        else if (~|dat_hist_d) pdata_d = 1'b0;
    end

    assign fall = pclk_prev_q & ~pclk_q;

    // ---------------- bus decode ----------------
    assign acc   = bus.stb_i & ~ack_q;
    assign wr_tx = acc & bus.we_i & ~bus.adr_i[2];
    assign wr_st = acc & bus.we_i &  bus.adr_i[2];
    assign busy  = (state_q != IDLE);

    assign rdata = bus.adr_i[2] ? {27'h0, ovr_q, tmo_q, nak_q, done_q, busy}
                                : {24'h0, tx_q};

    // Frame bit n is what the line carries after the n-th falling edge.
    assign frame = {1'b1, ~^tx_q, tx_q, 1'b0};

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        cyc_d    = cyc_q + 1'b1;
        tx_d     = tx_q;
        set_ovr  = 1'b0;
        set_tmo  = 1'b0;
        set_nak  = 1'b0;
        set_done = 1'b0;

        case (state_q)
            IDLE: begin
                cyc_d = '0;
                n_d   = '0;
                if (wr_tx) begin
                    tx_d    = bus.dat_i[7:0];
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cyc_q == CW'(INHIBIT_CYC - 1)) begin
                    cyc_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                n_d     = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (fall) begin
                    n_d = n_q + 4'd1;
                    if (n_q == 4'd9) state_d = ACK;
                end
            end
            ACK: begin
                if (fall) begin
                    if (pdata_q) begin
                        set_nak = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAITREL;
                    end
                end
            end
            WAITREL: begin
                cyc_d = cyc_q;
                if (pclk_q && pdata_q) begin
                    set_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Timeout covers the whole device-clocked part of the transfer and
        // takes precedence over a simultaneous ACK decision.
        if ((state_q == REQ || state_q == SHIFT || state_q == ACK) &&
            cyc_q == CW'(TIMEOUT_CYC - 1)) begin
            set_tmo = 1'b1;
            set_nak = 1'b0;
            state_d = IDLE;
        end

        if (wr_tx && state_q != IDLE) set_ovr = 1'b1;
    end

    // ---------------- registered outputs / flags ----------------
    always_comb begin
        ack_d     = bus.stb_i & ~ack_q;
        dat_o_d   = acc ? rdata : dat_o_q;
        clk_oe_d  = (state_q == INHIBIT);
        data_oe_d = (state_q == REQ) || (state_q == SHIFT && !frame[n_q]);
        // Set wins over a simultaneous write-1-to-clear.
        ovr_d  = set_ovr  | (ovr_q  & ~(wr_st & bus.dat_i[4]));
        tmo_d  = set_tmo  | (tmo_q  & ~(wr_st & bus.dat_i[3]));
        nak_d  = set_nak  | (nak_q  & ~(wr_st & bus.dat_i[2]));
        done_d = set_done | (done_q & ~(wr_st & bus.dat_i[1]));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cyc_q       <= '0;
            n_q         <= '0;
            tx_q        <= '0;
            ovr_q       <= 1'b0;
            tmo_q       <= 1'b0;
            nak_q       <= 1'b0;
            done_q      <= 1'b0;
            ack_q       <= 1'b0;
            dat_o_q     <= '0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            clk_sync_q  <= '1;
            dat_sync_q  <= '1;
            clk_hist_q  <= '1;
            dat_hist_q  <= '1;
            pclk_q      <= 1'b1;
            pclk_prev_q <= 1'b1;
            pdata_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            n_q         <= n_d;
            tx_q        <= tx_d;
            ovr_q       <= ovr_d;
            tmo_q       <= tmo_d;
            nak_q       <= nak_d;
            done_q      <= done_d;
            ack_q       <= ack_d;
            dat_o_q     <= dat_o_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q  <= {dat_sync_q[0], ps2_data_i};
            clk_hist_q  <= clk_hist_d;
            dat_hist_q  <= dat_hist_d;
            pclk_q      <= pclk_d;
            pclk_prev_q <= pclk_q;
            pdata_q     <= pdata_d;
        end
    end

    assign bus.ack_o   = ack_q;
    assign bus.dat_o   = dat_o_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_tx
//   Drives ps2_tx through its bus port and a behavioural PS/2 keyboard that
//   clocks at 1/400 of clk. Expected frames come from the byte via popcount.
// ----------------------------------------------------------------------------
module tb_ps2_tx;

    localparam int unsigned INH  = 200;
    localparam int unsigned TMO  = 5000;
    localparam int unsigned FLT  = 4;
    localparam int unsigned HALF = 200;
    localparam logic [31:0] A_TX = 32'h0;
    localparam logic [31:0] A_ST = 32'h4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe, busy;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ps2_tx_if bus ();

    // Open-drain wired lines with pull-ups.
    assign ps2_clk_i  = ~(ps2_clk_oe  | dev_clk_low);
    assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

    ps2_tx #(
        .INHIBIT_CYC (INH),
        .TIMEOUT_CYC (TMO),
        .FILTER_LEN  (FLT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = (($countones(b) % 2) == 0);
        f[10]  = 1'b1;
        return f;
    endfunction

    task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] r);
        int n;
        n = 0;
        @(negedge clk);
        bus.stb_i = 1'b1;
        bus.we_i  = w;
        bus.adr_i = a;
        bus.dat_i = d;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.ack_o && n < 4);
        if (!bus.ack_o) check("bus_ack", 32'd0, 32'd1);
        r = bus.dat_o;
        @(negedge clk);
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus_xfer(1'b1, a, d, r);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] r);
        bus_xfer(1'b0, a, 32'h0, r);
    endtask

    task automatic wait_rts(output bit seen);
        int t;
        t = 0;
        while (!(ps2_data_oe && !ps2_clk_oe) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        seen = ps2_data_oe && !ps2_clk_oe;
        if (!seen) check("rts_seen", 32'd0, 32'd1);
    endtask

    // Keyboard: samples data at the end of each low phase, optionally acks,
    // optionally injects a 1-cycle clock glitch during high phase of bit g.
    task automatic dev_frame(input bit do_ack, input int g, output logic [10:0] got);
        bit seen;
        got = '1;
        wait_rts(seen);
        if (!seen) return;
        repeat (50) @(negedge clk);
        got[0] = ps2_data_i;
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            got[k] = ps2_data_i;
            dev_clk_low = 1'b0;
            if (k == g) begin
                repeat (HALF / 2) @(negedge clk);
                dev_clk_low = 1'b1;
                @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (HALF / 2 - 1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        if (do_ack) dev_data_low = 1'b1;
        repeat (50) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (50) @(negedge clk);
        dev_data_low = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    task automatic send_check(input logic [7:0] b, input bit do_ack, input int g, input string tag);
        logic [10:0] got;
        logic [31:0] r;
        wr(A_TX, {24'h0, b});
        dev_frame(do_ack, g, got);
        check({tag, "_frame"}, {21'h0, got}, {21'h0, exp_frame(b)});
        repeat (20) @(negedge clk);
        rd(A_ST, r);
        check({tag, "_status"}, r, do_ack ? 32'h02 : 32'h04);
        check({tag, "_lines"}, {30'h0, ps2_clk_oe, ps2_data_oe}, 32'h0);
        wr(A_ST, 32'h1E);
    endtask

    initial begin : main
        logic [31:0] r;
        logic [10:0] got;
        logic [7:0]  b;
        bit          seen, ak;
        int          cnt;

        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
        bus.adr_i = '0;
        bus.dat_i = '0;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_ack",  {31'h0, bus.ack_o}, 32'h0);
        check("rst_dat",  bus.dat_o, 32'h0);
        check("rst_oe",   {30'h0, ps2_clk_oe, ps2_data_oe}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0xED with inhibit-length measurement
        wr(A_TX, 32'hED);
        cnt = 0;
        while (!ps2_clk_oe && cnt < 10) begin @(negedge clk); cnt++; end
        cnt = 0;
        while (ps2_clk_oe && cnt < 1000) begin @(negedge clk); cnt++; end
        check("inhibit_len", cnt, INH);
        dev_frame(1'b1, 0, got);
        check("ed_frame", {21'h0, got}, {21'h0, exp_frame(8'hED)});
        repeat (20) @(negedge clk);
        rd(A_ST, r);
        check("ed_status", r, 32'h02);
        check("ed_busy", {31'h0, busy}, 32'h0);
        wr(A_ST, 32'h1E);

        send_check(8'h01, 1'b1, 0, "b01");
        send_check(8'h00, 1'b1, 0, "b00");
        send_check(8'hFF, 1'b1, 0, "bff");
        send_check(8'hC3, 1'b0, 0, "nak");

        // Write while busy: overrun, original byte kept
        wr(A_TX, 32'hED);
        wr(A_TX, 32'hAA);
        dev_frame(1'b1, 0, got);
        check("ovr_frame", {21'h0, got}, {21'h0, exp_frame(8'hED)});
        repeat (20) @(negedge clk);
        rd(A_ST, r);
        check("ovr_status", r, 32'h12);
        rd(A_TX, r);
        check("ovr_txdata", r, 32'hED);
        wr(A_ST, 32'h1E);
        rd(A_ST, r);
        check("w1c_all", r, 32'h00);

        // Clock glitch must not advance the bit counter
        send_check(8'h3C, 1'b1, 4, "glitch");

        // Randomized bytes and ack/nak outcomes
        for (int i = 0; i < 3; i++) begin
            b  = 8'($urandom);
            ak = bit'($urandom_range(0, 3) != 0);
            send_check(b, ak, 0, "rand");
        end

        // Timeout: device never clocks
        wr(A_TX, 32'h5A);
        wait_rts(seen);
        cnt = 0;
        while (ps2_data_oe && cnt < 6000) begin @(negedge clk); cnt++; end
        check("tmo_len", cnt, TMO);
        check("tmo_lines", {30'h0, ps2_clk_oe, ps2_data_oe}, 32'h0);
        repeat (5) @(negedge clk);
        rd(A_ST, r);
        check("tmo_status", r, 32'h08);
        wr(A_ST, 32'h08);
        rd(A_ST, r);
        check("tmo_w1c", r, 32'h00);

        // Reset mid-frame after the 5th fall
        wr(A_TX, 32'h96);
        wait_rts(seen);
        repeat (50) @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            dev_clk_low = 1'b1;
            if (k < 5) begin
                repeat (HALF) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (HALF) @(negedge clk);
            end else begin
                repeat (HALF / 2) @(negedge clk);
            end
        end
        check("mid_busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_lines", {30'h0, ps2_clk_oe, ps2_data_oe}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        dev_clk_low = 1'b0;
        repeat (20) @(negedge clk);
        rd(A_ST, r);
        check("mid_rst_status", r, 32'h00);
        rd(A_TX, r);
        check("mid_rst_txdata", r, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
